// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Holds the FSM state set, the PC increment and the J-type index width.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam int          JUMP_INDEX_W     = 26;

endpackage

// File: rtl/pc_sequencer_jump_target_gen.sv
// J-type jump target builder: upper PC+4 nibble, 26-bit word index, two zero bits.
module jump_target_gen
    import pc_sequencer_pkg::*;
(
    input  logic [3:0]              pc_nibble_i,
    input  logic [JUMP_INDEX_W-1:0] jump_index_i,
    output logic [31:0]             jump_target_o
);

    assign jump_target_o = {pc_nibble_i, jump_index_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: arbitrates EX redirects, ID jumps, stalls and sequential
// fetch, tracks the imem handshake and raises the pipeline flush strobes.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          CNT_W        = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    stall_i,
    input  logic                    id_jump_i,
    input  logic [JUMP_INDEX_W-1:0] id_jump_index_i,
    input  logic [31:0]             id_pc_plus4_i,
    input  logic                    ex_branch_taken_i,
    input  logic [31:0]             ex_branch_target_i,
    input  logic                    ex_jr_i,
    input  logic [31:0]             ex_jr_target_i,
    input  logic                    imem_ready_i,
    output logic                    imem_req_o,
    output logic [31:0]             pc_o,
    output logic [31:0]             pc_plus4_o,
    output logic                    flush_if_id_o,
    output logic                    flush_id_ex_o,
    output logic [CNT_W-1:0]        redirect_count_o
);

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_WAIT = WAIT;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pending_pc_q, pending_pc_d;
    logic             pending_valid_q, pending_valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             in_boot;
    logic             ex_redirect;
    logic             id_jump_eff;
    logic             redirect;
    logic [31:0]      ex_target;
    logic [31:0]      jump_target;
    logic [31:0]      redirect_target;
    logic [31:0]      pc_plus4;
    logic [31:0]      hold_or_seq;

    // Only the top nibble of the ID PC+4 feeds the jump target.
    logic             unused_pc4_low;
    assign unused_pc4_low = ^id_pc_plus4_i[27:0];

    jump_target_gen u_jump_target_gen (
        .pc_nibble_i   (id_pc_plus4_i[31:28]),
        .jump_index_i  (id_jump_index_i),
        .jump_target_o (jump_target)
    );

    assign in_boot     = (state_q == ST_BOOT);
    assign ex_redirect = ex_branch_taken_i | ex_jr_i;
    assign ex_target   = ex_jr_i ? ex_jr_target_i : ex_branch_target_i;
    // The stalled ID instruction is not advancing, so its jump is not taken yet.
    assign id_jump_eff = id_jump_i & ~stall_i;
    assign redirect    = ~in_boot & (ex_redirect | id_jump_eff);

    // The older instruction (EX) wins over the younger one (ID).
    assign redirect_target = ex_redirect ? ex_target : jump_target;

    assign pc_plus4    = pc_q + PC_INC;
    assign hold_or_seq = stall_i ? pc_q : pc_plus4;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pending_pc_d    = pending_pc_q;
        pending_valid_d = pending_valid_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (imem_ready_i) begin
                    if (pending_valid_q) begin
                        pc_d = pending_pc_q;
                    end else if (redirect) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d = hold_or_seq;
                    end
                    pending_valid_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    if (redirect) begin
                        pending_pc_d    = redirect_target;
                        pending_valid_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A redirect arriving while waiting replaces any captured one.
                if (imem_ready_i) begin
                    if (redirect) begin
                        pc_d = redirect_target;
                    end else if (pending_valid_q) begin
                        pc_d = pending_pc_q;
                    end else begin
                        pc_d = hold_or_seq;
                    end
                    pending_valid_d = 1'b0;
                    state_d         = ST_RUN;
                end else if (redirect) begin
                    pending_pc_d    = redirect_target;
                    pending_valid_d = 1'b1;
                end
            end
            default: begin
                state_d         = ST_BOOT;
                pending_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (redirect && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VECTOR;
            pending_pc_q    <= RESET_VECTOR;
            pending_valid_q <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pending_pc_q    <= pending_pc_d;
            pending_valid_q <= pending_valid_d;
            count_q         <= count_d;
        end
    end

    assign imem_req_o       = ~in_boot;
    assign pc_o             = pc_q;
    assign pc_plus4_o       = pc_plus4;
    assign flush_if_id_o    = redirect;
    assign flush_id_ex_o    = ~in_boot & ex_redirect;
    assign redirect_count_o = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// cycle by cycle against a behavioural fetch model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, id_jump, ex_br, ex_jr, ready;
    logic [25:0] id_idx;
    logic [31:0] id_pc4, ex_br_t, ex_jr_t;

    logic        req_a, fif_a, fie_a, req_b, fif_b, fie_b;
    logic [31:0] pc_a, pc4_a, pc_b, pc4_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    int unsigned m_cnt, m_cnt2;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(RV), .CNT_W(16)) dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .id_jump_i(id_jump),
        .id_jump_index_i(id_idx), .id_pc_plus4_i(id_pc4),
        .ex_branch_taken_i(ex_br), .ex_branch_target_i(ex_br_t),
        .ex_jr_i(ex_jr), .ex_jr_target_i(ex_jr_t), .imem_ready_i(ready),
        .imem_req_o(req_a), .pc_o(pc_a), .pc_plus4_o(pc4_a),
        .flush_if_id_o(fif_a), .flush_id_ex_o(fie_a), .redirect_count_o(cnt_a)
    );

    pc_sequencer #(.RESET_VECTOR(RV), .CNT_W(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .id_jump_i(id_jump),
        .id_jump_index_i(id_idx), .id_pc_plus4_i(id_pc4),
        .ex_branch_taken_i(ex_br), .ex_branch_target_i(ex_br_t),
        .ex_jr_i(ex_jr), .ex_jr_target_i(ex_jr_t), .imem_ready_i(ready),
        .imem_req_o(req_b), .pc_o(pc_b), .pc_plus4_o(pc4_b),
        .flush_if_id_o(fif_b), .flush_id_ex_o(fie_b), .redirect_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic jmp, input logic [25:0] idx,
                         input logic [31:0] p4, input logic br, input logic [31:0] brt,
                         input logic jr, input logic [31:0] jrt, input logic rdy);
        stall = st; id_jump = jmp; id_idx = idx; id_pc4 = p4;
        ex_br = br; ex_br_t = brt; ex_jr = jr; ex_jr_t = jrt; ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = RV;
        m_pend.delete();
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // Called just after inputs are driven at the falling edge: check, then advance model.
    task automatic step();
        bit          red;
        logic [31:0] tgt;
        #1;
        red = !m_boot && (ex_br || ex_jr || (id_jump && !stall));
        if (ex_jr)      tgt = ex_jr_t;
        else if (ex_br) tgt = ex_br_t;
        else            tgt = (id_pc4 & 32'hF000_0000) | ({6'd0, id_idx} << 2);

        check("pc",          pc_a,  m_pc);
        check("pc_plus4",    pc4_a, m_pc + 32'd4);
        check("imem_req",    {31'd0, req_a}, {31'd0, !m_boot});
        check("flush_if_id", {31'd0, fif_a}, {31'd0, red});
        check("flush_id_ex", {31'd0, fie_a}, {31'd0, !m_boot && (ex_br || ex_jr)});
        check("count16",     {16'd0, cnt_a}, m_cnt);
        check("count2",      {30'd0, cnt_b}, m_cnt2);
        check("pc_w2",       pc_b,  m_pc);

        if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            if (red) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3)    m_cnt2++;
            end
            if (ready) begin
                if (red)                  m_pc = tgt;
                else if (m_pend.size())   m_pc = m_pend[0];
                else if (!stall)          m_pc = m_pc + 32'd4;
                m_pend.delete();
            end else if (red) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_pc", pc_a, RV);
        check("reset_req", {31'd0, req_a}, 32'd0);
        check("reset_cnt", {16'd0, cnt_a}, 32'd0);
        reset = 1'b0;

        // Boot then sequential fetch
        for (int i = 0; i < 4; i++) step();
        check("t1_pc_seq", pc_a, 32'h0000_000C);
        $display("t1 sequential fetch: pc=0x%08h", pc_a);

        // ID jump
        drive(1'b0, 1'b1, 26'h0000123, 32'h4000_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step();
        check("t2_jump_pc", pc_a, 32'h4000_048C);
        check("t2_count", {16'd0, cnt_a}, 32'd1);
        $display("t2 id jump: pc=0x%08h count=%0d", pc_a, cnt_a);

        // EX branch beats ID jump
        drive(1'b0, 1'b1, 26'h0000123, 32'h4000_0010, 1'b1, 32'h0000_0100, 1'b0, 32'd0, 1'b1);
        step();
        check("t3_branch_pc", pc_a, 32'h0000_0100);
        check("t3_count", {16'd0, cnt_a}, 32'd2);
        $display("t3 branch over jump: pc=0x%08h count=%0d", pc_a, cnt_a);

        // Stall at 0x20, jump during stall ignored
        drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b1, 32'h0000_0020, 1'b0, 32'd0, 1'b1);
        step();
        idle(1'b1); stall = 1'b1; step();
        id_jump = 1'b1; id_idx = 26'h3FF; id_pc4 = 32'h8000_0000; step();
        idle(1'b1); stall = 1'b1; step();
        check("t4_stall_pc", pc_a, 32'h0000_0020);
        idle(1'b1); step();
        check("t4_after_stall", pc_a, 32'h0000_0024);
        $display("t4 stall: pc=0x%08h", pc_a);

        // JR while imem not ready
        drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0800, 1'b0);
        step();
        idle(1'b0); step();
        check("t5_wait_pc", pc_a, 32'h0000_0024);
        idle(1'b1); step();
        check("t5_jr_pc", pc_a, 32'h0000_0800);
        $display("t5 jr across wait: pc=0x%08h", pc_a);

        // Async reset in WAIT with a pending redirect
        drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b1, 32'h0000_4444, 1'b0, 32'd0, 1'b0);
        step();
        #3 reset = 1'b1;
        #1;
        check("t6_async_pc", pc_a, RV);
        check("t6_async_req", {31'd0, req_a}, 32'd0);
        model_reset();
        idle(1'b1);
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        check("t6_pending_dropped", pc_a, RV + 32'd4);
        $display("t6 reset in wait: pc=0x%08h", pc_a);

        // Five redirects: narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 26'(i * 16), 32'h1000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
            step();
        end
        check("t6_count2_sat", {30'd0, cnt_b}, 32'd3);
        check("t6_count16", {16'd0, cnt_a}, 32'd5);
        $display("t6 saturation: count16=%0d count2=%0d", cnt_a, cnt_b);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) begin
                reset = 1'b1;
                model_reset();
                #1;
                check("rand_reset_pc", pc_a, RV);
                @(negedge clk);
                reset = 1'b0;
            end
            drive($urandom_range(99) < 20, $urandom_range(99) < 20, 26'($urandom),
                  $urandom, $urandom_range(99) < 15, $urandom,
                  $urandom_range(99) < 10, $urandom, $urandom_range(99) < 75);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-stage controller that owns the program counter of the 5-stage MIPS pipeline and sequences next-PC selection.
- Builds the J-type jump target (upper PC+4 nibble, 26-bit index, two zero bits).
- Arbitrates among EX-stage redirects (taken branch, JR), ID-stage jumps, hazard stalls and sequential fetch.
- Handles a ready/request handshake with instruction memory and emits the IF/ID and ID/EX flush strobes.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit load-use stall: hold PC
id_jump  in  1  J/JAL decoded in ID this cycle
id_jump_index  in  26  instr[25:0] of the ID instruction
id_pc_plus4  in  32  PC+4 of the ID instruction
ex_branch_taken  in  1  branch in EX resolved taken
ex_branch_target  in  32  branch target from EX adder
ex_jr  in  1  JR in EX
ex_jr_target  in  32  register value for JR
imem_ready  in  1  instruction memory accepts/returns fetch this cycle
imem_req  out  1  fetch request for address pc
pc  out  32  current fetch address
pc_plus4  out  32  pc + 4, combinational, wraps modulo 2^32
flush_if_id  out  1  kill instruction in IF/ID
flush_id_ex  out  1  kill instruction in ID/EX
redirect_count  out  CNT_W  number of accepted redirects, saturating

Behaviour:
- Reset (async, active-high):
  - pc = RESET_VECTOR, state = BOOT.
  - pending_valid = 0, redirect_count = 0.
  - imem_req = 0, flush_if_id = 0, flush_id_ex = 0.
  - Reset asserted mid-operation discards pending redirects.
- jump_target = {id_pc_plus4[31:28], id_jump_index, 2'b00}.
- ex_redirect = ex_branch_taken | ex_jr.
- ex_target = ex_jr ? ex_jr_target : ex_branch_target. ex_jr has priority if both are asserted.
- Redirect priority per cycle (older instruction wins):
  1. ex_redirect
  2. id_jump
  3. stall
  4. sequential (pc_plus4)
- Stall arbitration:
  - A redirect overrides stall.
  - id_jump is ignored while stall is high, because the ID instruction is not advancing.
- Flushes, combinational, the same cycle the redirect is accepted:
  - flush_if_id = ex_redirect | (id_jump & ~stall).
  - flush_id_ex = ex_redirect.
  - Flushes are independent of imem_ready.
- FSM states:
  - BOOT: imem_req = 0 for exactly one cycle after reset release, then go to RUN. Redirect inputs are ignored in BOOT.
  - RUN: imem_req = 1.
    - If imem_ready = 1: pc <= selected next PC (pending_pc if pending_valid, else by priority); pending_valid <= 0.
    - If imem_ready = 0: pc held, go to WAIT; any redirect this cycle is captured into pending_pc/pending_valid.
  - WAIT: imem_req = 1, pc held.
    - A new redirect overwrites pending_pc, with the same priority rules.
    - On imem_ready = 1: pc <= pending_valid ? pending_pc : (stall ? pc : pc_plus4); clear pending; go to RUN.
- Stall with imem_ready = 1 in RUN: pc held, imem_req stays 1, so the same address is refetched.
- redirect_count increments by 1 per cycle in which a redirect is accepted (not in BOOT). It saturates at all-ones and does not wrap.
- The PC low two bits are not checked; misaligned targets pass through unchanged.
- Latency: a redirect accepted in cycle N with imem_ready = 1 puts the target on pc in cycle N+1.

Decomposition:
- Shared package holds:
  - state enum {BOOT, RUN, WAIT};
  - RESET_VECTOR default;
  - constant PC_INC = 32'd4;
  - JUMP_INDEX_W = 26.
- One natural sub-module: jump_target_gen (combinational {nibble, index, 2'b00} builder), instantiated once.
- All sequencing stays in pc_sequencer.

Test Plan:
1. Reset release, imem_ready = 1, no events -> imem_req low for 1 cycle; pc = 0x0, 0x4, 0x8, 0xC on successive cycles.
2. id_jump with id_pc_plus4 = 0x4000_0010 and index 0x0000_123 -> next pc = 0x4000_048C; flush_if_id = 1, flush_id_ex = 0; redirect_count = 1.
3. ex_branch_taken (target 0x0000_0100) and id_jump in the same cycle -> pc = 0x100; both flushes = 1; redirect_count increments by 1 only.
4. stall = 1 for 3 cycles at pc = 0x20 -> pc holds 0x20 and imem_req stays 1; id_jump during the stall is ignored with no flush; pc = 0x24 after the stall drops.
5. imem_ready low for 2 cycles while ex_jr (target 0x0000_0800) arrives -> pc held and flushes pulse once; pc = 0x800 the cycle after imem_ready rises.
6. Reset asserted while in WAIT with a pending redirect -> pc = RESET_VECTOR immediately and the pending redirect is dropped. Separately, with CNT_W = 2, 5 redirects -> redirect_count = 3.
